screen_saver_bouncer: RTL and testbench
=======================================

Name: screen_saver_bouncer

Overview:
- Parametrised successor to the single-ball screen saver pattern.
- A square sprite moves in X and Y, bounces off all four edges of the active area, and steps through an 8-entry colour palette on each bounce.
- Sits between the VGA timing generator (supplies x/y) and the pattern mux.
- Pixel output is registered. Position is exported for the overlay/debug logic.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BALL_HALF, 10, half side of the sprite; sprite is (2*BALL_HALF+1) pixels square.
- PRESCALE_MAX, 65536, clock cycles per movement tick (>=2).
- STEP_X, 1, pixels moved in X per tick (1..H_ACTIVE-2*BALL_HALF-1).
- STEP_Y, 1, pixels moved in Y per tick (1..V_ACTIVE-2*BALL_HALF-1).
- START_X, 100, reset centre X; must lie in [BALL_HALF, H_ACTIVE-1-BALL_HALF].
- START_Y, 100, reset centre Y; must lie in [BALL_HALF, V_ACTIVE-1-BALL_HALF].

Ports:
- clock25MHz  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = motion runs; 0 = freeze (drawing continues).
- x  in  10  current pixel column from timing generator.
- y  in  10  current pixel row from timing generator.
- red  out  4  pixel red, registered.
- green  out  4  pixel green, registered.
- blue  out  4  pixel blue, registered.
- ball_x  out  10  current sprite centre X.
- ball_y  out  10  current sprite centre Y.
- bounce  out  1  one-cycle pulse per bounce event.

Behaviour:
- Reset, sampled on clock25MHz rising edge, overrides everything, including mid-tick:
  - prescaler=0, ball_x=START_X, ball_y=START_Y, dir_x=+, dir_y=+, colour index=0
  - red/green/blue=0, bounce=0.
- Prescaler:
  - Counts 0..PRESCALE_MAX-1 and wraps while enable=1; holds its value while enable=0.
  - tick = (prescaler==PRESCALE_MAX-1) && enable.
- On tick, each axis is updated independently. Limits: XMIN=BALL_HALF, XMAX=H_ACTIVE-1-BALL_HALF (Y likewise, using V_ACTIVE).
  - Moving +: if pos+STEP > MAX, then pos<=MAX, dir flips, axis bounce; else pos<=pos+STEP.
  - Moving −: if pos < MIN+STEP, then pos<=MIN, dir flips, axis bounce; else pos<=pos-STEP.
  - Compare in at least 11 bits; no wrap-around or underflow allowed.
- Bounce event = X bounce OR Y bounce on the same tick.
  - A corner hit (both axes on the same tick) counts as ONE event.
  - bounce is high for exactly the one cycle after the tick edge, when ball_x/ball_y update.
  - Colour index increments by 1, mod 8, in that same update.
- Palette, index→RGB:
  - 0 FFF, 1 F00, 2 0F0, 3 00F, 4 FF0, 5 0FF, 6 F0F, 7 F80.
- Pixel path, 1-cycle latency:
  - Inside = x+BALL_HALF >= ball_x AND x <= ball_x+BALL_HALF AND the same test for y, evaluated in 11 bits.
  - Inside is forced to 0 if x>=H_ACTIVE or y>=V_ACTIVE.
  - On the next edge: RGB <= inside ? palette[index] : 0.
  - Uses ball position and index as registered before the edge. A position change takes effect on pixels presented in the cycle after the update.
- enable=0:
  - Prescaler, position, direction and index all freeze; bounce stays 0.
  - Drawing continues.
  - On return to 1, counting resumes from the held prescaler value.
- ball_x/ball_y are driven directly from the position registers.

Test Plan:
- Reset, then x=100,y=100 → next cycle RGB=FFF. x=111,y=100 → 000. x=90,y=110 → FFF. x=89 → 000. ball_x=100, ball_y=100, bounce=0.
- PRESCALE_MAX=4, START_X=627, STEP_X=1, H_ACTIVE=640, BALL_HALF=10:
  - Successive ticks give ball_x=628, 629, then 629 with bounce pulse and index=1.
  - RGB inside the sprite = F00.
  - Next tick ball_x=628.
- Corner: START_X=629, START_Y=469, V_ACTIVE=480, PRESCALE_MAX=4:
  - First tick flips both directions with a single bounce pulse; index 0→1, not 2.
  - Following tick gives (628,468).
- Left/top underflow: STEP_X=3, ball moving − at ball_x=12 → clamps to 10 with bounce; no wrap to ~1020.
- enable=0 for 50 cycles mid-prescale → ball_x, index and prescaler unchanged, bounce=0.
  - After re-enable, the tick arrives exactly the remaining count later.
- Assert reset for one cycle in the cycle a tick would fire → no move, no bounce.
  - State returns to START_X/START_Y, dir +,+, index 0; RGB=0 on the following cycle.

Source files
------------

// File: rtl/screen_saver_bouncer.sv
// Bouncing square sprite for the screen-saver pattern: moves one step per prescaler tick,
// reflects off all four edges of the active area and cycles an 8-colour palette per bounce.
module screen_saver_bouncer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_HALF    = 10,
    parameter int PRESCALE_MAX = 65536,
    parameter int STEP_X       = 1,
    parameter int STEP_Y       = 1,
    parameter int START_X      = 100,
    parameter int START_Y      = 100
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       bounce
);

    localparam int PW = $clog2(PRESCALE_MAX);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_MAX - 1);

    localparam logic [10:0] XMIN   = 11'(BALL_HALF);
    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - 1 - BALL_HALF);
    localparam logic [10:0] YMIN   = 11'(BALL_HALF);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - 1 - BALL_HALF);
    localparam logic [10:0] STEPX  = 11'(STEP_X);
    localparam logic [10:0] STEPY  = 11'(STEP_Y);
    localparam logic [10:0] HALF   = 11'(BALL_HALF);
    localparam logic [10:0] HACT   = 11'(H_ACTIVE);
    localparam logic [10:0] VACT   = 11'(V_ACTIVE);

    logic [PW-1:0] prescaler;
    logic          dir_x;        // 1 = moving towards larger coordinates
    logic          dir_y;
    logic [2:0]    colour_idx;
    logic          tick;
    logic [9:0]    nx, ny;
    logic          ndir_x, ndir_y;
    logic          hit_x, hit_y;
    logic          inside_p0;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'hFFF;
            3'd1:    palette = 12'hF00;
            3'd2:    palette = 12'h0F0;
            3'd3:    palette = 12'h00F;
            3'd4:    palette = 12'hFF0;
            3'd5:    palette = 12'h0FF;
            3'd6:    palette = 12'hF0F;
            default: palette = 12'hF80;
        endcase
    endfunction

    // One axis of motion; all compares are 11 bits wide so neither edge can wrap.
    function automatic void axis_step(
        input  logic [9:0]  pos,
        input  logic        dir,
        input  logic [10:0] lo,
        input  logic [10:0] hi,
        input  logic [10:0] step,
        output logic [9:0]  npos,
        output logic        ndir,
        output logic        hit
    );
        logic [10:0] pos_w;
        logic [10:0] sum;
        logic [10:0] diff;
        pos_w = {1'b0, pos};
        sum   = pos_w + step;
        diff  = pos_w - step;
        npos  = pos;
        ndir  = dir;
        hit   = 1'b0;
        if (dir) begin
            if (sum > hi) begin
                npos = hi[9:0];
                ndir = 1'b0;
                hit  = 1'b1;
            end else begin
                npos = sum[9:0];
            end
        end else begin
            if (pos_w < lo + step) begin
                npos = lo[9:0];
                ndir = 1'b1;
                hit  = 1'b1;
            end else begin
                npos = diff[9:0];
            end
        end
    endfunction

    always_comb begin
        tick   = enable && (prescaler == PRE_LAST);
        nx     = ball_x;
        ny     = ball_y;
        ndir_x = dir_x;
        ndir_y = dir_y;
        hit_x  = 1'b0;
        hit_y  = 1'b0;
        axis_step(ball_x, dir_x, XMIN, XMAX, STEPX, nx, ndir_x, hit_x);
        axis_step(ball_y, dir_y, YMIN, YMAX, STEPY, ny, ndir_y, hit_y);
    end

    // Stage p0: sprite hit test against the position held before this edge
    always_comb begin
        inside_p0 = ({1'b0, x} + HALF >= {1'b0, ball_x}) &&
                    ({1'b0, x} <= {1'b0, ball_x} + HALF) &&
                    ({1'b0, y} + HALF >= {1'b0, ball_y}) &&
                    ({1'b0, y} <= {1'b0, ball_y} + HALF) &&
                    ({1'b0, x} < HACT) && ({1'b0, y} < VACT);
    end

    // Stage p1: registered pixel plus motion state
    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            prescaler  <= '0;
            ball_x     <= 10'(START_X);
            ball_y     <= 10'(START_Y);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            colour_idx <= 3'd0;
            bounce     <= 1'b0;
            red        <= 4'h0;
            green      <= 4'h0;
            blue       <= 4'h0;
        end else begin
            if (enable)
                prescaler <= tick ? '0 : prescaler + PW'(1);
            bounce <= tick && (hit_x || hit_y);
            if (tick) begin
                ball_x <= nx;
                ball_y <= ny;
                dir_x  <= ndir_x;
                dir_y  <= ndir_y;
                if (hit_x || hit_y)
                    colour_idx <= colour_idx + 3'd1;
            end
            {red, green, blue} <= inside_p0 ? palette(colour_idx) : 12'h000;
        end
    end

endmodule

// File: tb/tb_screen_saver_bouncer.sv
// Directed bench for screen_saver_bouncer: four instances with different geometry/start
// parameters cover drawing, right/bottom and left edge bounces, corners, freeze and reset.
module tb_screen_saver_bouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] x, y;
    logic rst_d, rst_a, rst_b, rst_c;
    logic en_d, en_a, en_b, en_c;

    logic [3:0] r_d, g_d, b_d, r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [9:0] bx_d, by_d, bx_a, by_a, bx_b, by_b, bx_c, by_c;
    logic bn_d, bn_a, bn_b, bn_c;

    int n_checks = 0;
    int n_pass   = 0;

    screen_saver_bouncer #(.PRESCALE_MAX(100)) u_d (
        .clock25MHz(clk), .reset(rst_d), .enable(en_d), .x(x), .y(y),
        .red(r_d), .green(g_d), .blue(b_d), .ball_x(bx_d), .ball_y(by_d), .bounce(bn_d));

    screen_saver_bouncer #(.PRESCALE_MAX(4), .START_X(627)) u_a (
        .clock25MHz(clk), .reset(rst_a), .enable(en_a), .x(x), .y(y),
        .red(r_a), .green(g_a), .blue(b_a), .ball_x(bx_a), .ball_y(by_a), .bounce(bn_a));

    screen_saver_bouncer #(.PRESCALE_MAX(4), .START_X(629), .START_Y(469)) u_b (
        .clock25MHz(clk), .reset(rst_b), .enable(en_b), .x(x), .y(y),
        .red(r_b), .green(g_b), .blue(b_b), .ball_x(bx_b), .ball_y(by_b), .bounce(bn_b));

    screen_saver_bouncer #(.H_ACTIVE(41), .PRESCALE_MAX(4), .STEP_X(3), .START_X(30)) u_c (
        .clock25MHz(clk), .reset(rst_c), .enable(en_c), .x(x), .y(y),
        .red(r_c), .green(g_c), .blue(b_c), .ball_x(bx_c), .ball_y(by_c), .bounce(bn_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_bounce;
        rst_d = 1'b1; rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_d = 1'b1; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        x = 10'd100; y = 10'd100;
        cyc(2);
        check_val("rst_rgb", {r_d, g_d, b_d}, 12'h000);
        check_val("rst_bx", bx_d, 100);
        check_val("rst_by", by_d, 100);
        check_val("rst_bounce", bn_d, 0);

        // Drawing around the default sprite at (100,100)
        rst_d = 1'b0;
        cyc(1); check_val("pix_centre", {r_d, g_d, b_d}, 12'hFFF);
        x = 10'd111; cyc(1); check_val("pix_right_out", {r_d, g_d, b_d}, 12'h000);
        x = 10'd90; y = 10'd110; cyc(1); check_val("pix_corner_in", {r_d, g_d, b_d}, 12'hFFF);
        x = 10'd89; cyc(1); check_val("pix_left_out", {r_d, g_d, b_d}, 12'h000);
        x = 10'd110; y = 10'd90; cyc(1); check_val("pix_tr_in", {r_d, g_d, b_d}, 12'hFFF);
        check_val("d_bx_still", bx_d, 100);

        // Freeze at prescaler=30, then resume: tick must land 70 edges later
        cyc(25);
        en_d = 1'b0; x = 10'd100; y = 10'd100;
        saw_bounce = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (bn_d) saw_bounce = 1'b1;
        end
        check_val("frz_bx", bx_d, 100);
        check_val("frz_bounce", saw_bounce, 0);
        check_val("frz_draw", {r_d, g_d, b_d}, 12'hFFF);
        en_d = 1'b1;
        cyc(69); check_val("resume_early", bx_d, 100);
        cyc(1);  check_val("resume_tick_x", bx_d, 101);
        check_val("resume_tick_y", by_d, 101);

        // Right edge bounce from 627
        rst_a = 1'b0;
        cyc(4); check_val("a_t1", bx_a, 628); check_val("a_t1_bn", bn_a, 0);
        cyc(4); check_val("a_t2", bx_a, 629);
        cyc(4); check_val("a_t3", bx_a, 629); check_val("a_t3_bn", bn_a, 1);
        check_val("a_t3_y", by_a, 103);
        x = 10'd629; y = 10'd103;
        cyc(1); check_val("a_bn_pulse", bn_a, 0); check_val("a_rgb", {r_a, g_a, b_a}, 12'hF00);
        x = 10'd640;
        cyc(1); check_val("a_offscreen", {r_a, g_a, b_a}, 12'h000);
        cyc(2); check_val("a_t4", bx_a, 628);

        // Reset landing on the edge where a tick would fire
        cyc(3);
        rst_a = 1'b1; x = 10'd627; y = 10'd100;
        cyc(1);
        check_val("rt_bx", bx_a, 627); check_val("rt_by", by_a, 100);
        check_val("rt_bn", bn_a, 0); check_val("rt_rgb", {r_a, g_a, b_a}, 12'h000);
        rst_a = 1'b0;
        cyc(1); check_val("rt_idx0", {r_a, g_a, b_a}, 12'hFFF);
        cyc(3); check_val("rt_dirx", bx_a, 628); check_val("rt_diry", by_a, 101);

        // Corner: one bounce, index 0 -> 1
        rst_b = 1'b0;
        cyc(4);
        check_val("b_x", bx_b, 629); check_val("b_y", by_b, 469); check_val("b_bn", bn_b, 1);
        x = 10'd629; y = 10'd469;
        cyc(1); check_val("b_rgb", {r_b, g_b, b_b}, 12'hF00); check_val("b_bn_end", bn_b, 0);
        cyc(3); check_val("b_next_x", bx_b, 628); check_val("b_next_y", by_b, 468);

        // Left edge with STEP_X=3 in a 41-wide area
        rst_c = 1'b0;
        cyc(4); check_val("c_right", bx_c, 30); check_val("c_right_bn", bn_c, 1);
        check_val("c_y", by_c, 101);
        cyc(24); check_val("c_at12", bx_c, 12); check_val("c_at12_bn", bn_c, 0);
        cyc(4); check_val("c_clamp", bx_c, 10); check_val("c_clamp_bn", bn_c, 1);
        x = 10'd0; y = 10'd108;
        cyc(1); check_val("c_rgb_idx2", {r_c, g_c, b_c}, 12'h0F0);
        x = 10'd21;
        cyc(1); check_val("c_rgb_out", {r_c, g_c, b_c}, 12'h000);
        cyc(2); check_val("c_rebound", bx_c, 13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
